rf_update_sched: RTL and testbench



---
 rtl/rf_update_sched.sv | 124 ++++++++++++
 tb/tb_rf_update_sched.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/rf_update_sched.sv
// rf_update_sched: commit-side write scheduler for the rename register file.
//   Committed ROB results are buffered in a DEPTH-entry FIFO and drained one
//   per cycle into the RF value-update port. Rename updates pass straight
//   through to the RF dependency port. An ROB clear suppresses renames and
//   pauses draining, but never discards queued (architectural) results.
//
// Optional feature macro: RF_UPDATE_BYPASS_EN
//   defined   -> qry_id lookup of queued values (youngest match wins)
//   undefined -> qry_hit/qry_val tied to 0, no comparators
//
// Ports:
//   clk_in, rst_in (async, active-high), rdy_in (global stall when low)
//   rob_clear                              ROB flush
//   commit_valid/ready, commit_id/dep/val  commit enqueue handshake
//   rename_valid, rename_id/dep            rename pass-through input
//   is_update_val_out, update_val_id_out/update_val_dep_out/update_val_out
//                                          RF value port (FIFO head)
//   is_update_dep_out, update_dep_id_out/update_dep_out
//                                          RF dependency port
//   qry_id, qry_hit, qry_val               decoder lookup
`ifndef ROB_SIZE_BIT
`define ROB_SIZE_BIT 4
`endif

module rf_update_sched #(
  parameter int DEPTH = 4
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     rdy_in,
  input  logic                     rob_clear,
  input  logic                     commit_valid,
  output logic                     commit_ready,
  input  logic [4:0]               commit_id,
  input  logic [`ROB_SIZE_BIT-1:0] commit_dep,
  input  logic [31:0]              commit_val,
  input  logic                     rename_valid,
  input  logic [4:0]               rename_id,
  input  logic [`ROB_SIZE_BIT-1:0] rename_dep,
  output logic                     is_update_val_out,
  output logic [4:0]               update_val_id_out,
  output logic [`ROB_SIZE_BIT-1:0] update_val_dep_out,
  output logic [31:0]              update_val_out,
  output logic                     is_update_dep_out,
  output logic [4:0]               update_dep_id_out,
  output logic [`ROB_SIZE_BIT-1:0] update_dep_out,
  input  logic [4:0]               qry_id,
  output logic                     qry_hit,
  output logic [31:0]              qry_val
);
  localparam int TW = `ROB_SIZE_BIT;
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  logic [4:0]    mem_id  [DEPTH];
  logic [TW-1:0] mem_dep [DEPTH];
  logic [31:0]   mem_val [DEPTH];
  logic [PW-1:0] head, tail;
  logic [PW:0]   count;
  logic          push, pop;

  assign commit_ready      = rdy_in && (count != FULL);
  // Writes to x0 complete the handshake but are never queued.
  assign push              = commit_valid && commit_ready && (commit_id != 5'd0);
  assign is_update_val_out = (count != '0) && !rob_clear;
  assign pop               = rdy_in && is_update_val_out;

  assign update_val_id_out  = mem_id[head];
  assign update_val_dep_out = mem_dep[head];
  assign update_val_out     = mem_val[head];

  assign is_update_dep_out = rename_valid && !rob_clear;
  assign update_dep_id_out = rename_id;
  assign update_dep_out    = rename_dep;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_id[i]  <= '0;
        mem_dep[i] <= '0;
        mem_val[i] <= '0;
      end
    end else if (rdy_in) begin
      if (push) begin
        mem_id[tail]  <= commit_id;
        mem_dep[tail] <= commit_dep;
        mem_val[tail] <= commit_val;
        tail          <= tail + 1'b1;
      end
      if (pop) head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef RF_UPDATE_BYPASS_EN
  // Walk oldest to youngest so the last match (closest to tail) wins.
  logic [PW-1:0] idx;
  always_comb begin
    qry_hit = 1'b0;
    qry_val = '0;
    idx     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if (((PW+1)'(i) < count) && (mem_id[idx] == qry_id) && (qry_id != 5'd0)) begin
        qry_hit = 1'b1;
        qry_val = mem_val[idx];
      end
    end
  end
`else
  logic unused_qry;
  assign unused_qry = ^qry_id;
  assign qry_hit    = 1'b0;
  assign qry_val    = '0;
`endif

endmodule

// File: tb/tb_rf_update_sched.sv
`ifndef ROB_SIZE_BIT
`define ROB_SIZE_BIT 4
`endif

module tb_rf_update_sched;
  localparam int DEPTH = 4;
  localparam int TW = `ROB_SIZE_BIT;

  logic clk_in = 0, rst_in = 1, rdy_in = 1, rob_clear = 0;
  logic commit_valid = 0, commit_ready;
  logic [4:0] commit_id = 0;
  logic [TW-1:0] commit_dep = 0;
  logic [31:0] commit_val = 0;
  logic rename_valid = 0;
  logic [4:0] rename_id = 0;
  logic [TW-1:0] rename_dep = 0;
  logic is_update_val_out, is_update_dep_out, qry_hit;
  logic [4:0] update_val_id_out, update_dep_id_out, qry_id = 0;
  logic [TW-1:0] update_val_dep_out, update_dep_out;
  logic [31:0] update_val_out, qry_val;

  int checks = 0, errors = 0;

  rf_update_sched #(.DEPTH(DEPTH)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .rob_clear(rob_clear),
    .commit_valid(commit_valid), .commit_ready(commit_ready),
    .commit_id(commit_id), .commit_dep(commit_dep), .commit_val(commit_val),
    .rename_valid(rename_valid), .rename_id(rename_id), .rename_dep(rename_dep),
    .is_update_val_out(is_update_val_out), .update_val_id_out(update_val_id_out),
    .update_val_dep_out(update_val_dep_out), .update_val_out(update_val_out),
    .is_update_dep_out(is_update_dep_out), .update_dep_id_out(update_dep_id_out),
    .update_dep_out(update_dep_out), .qry_id(qry_id), .qry_hit(qry_hit), .qry_val(qry_val)
  );

  always #5 clk_in = ~clk_in;

  // Scoreboard: entries the FIFO should currently hold, oldest first.
  typedef struct { logic [4:0] id; logic [TW-1:0] dep; logic [31:0] val; } ent_t;
  ent_t sb[$];

  always @(posedge clk_in or posedge rst_in) begin
    if (rst_in) sb.delete();
    else begin
      bit do_pop, do_push;
      do_pop  = rdy_in && sb.size() != 0 && !rob_clear;
      do_push = rdy_in && commit_valid && sb.size() < DEPTH && commit_id != 0;
      if (do_pop) void'(sb.pop_front());
      if (do_push) sb.push_back('{commit_id, commit_dep, commit_val});
    end
  end

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Compare all outputs against the scoreboard model for the current inputs.
  task automatic check();
    logic eh; logic [31:0] ev;
    eh = 0; ev = 0;
`ifdef RF_UPDATE_BYPASS_EN
    if (qry_id != 0)
      foreach (sb[i]) if (sb[i].id == qry_id) begin eh = 1; ev = sb[i].val; end
`endif
    chk("commit_ready", 32'(commit_ready), 32'(rdy_in && sb.size() < DEPTH));
    chk("val_strobe", 32'(is_update_val_out), 32'(sb.size() != 0 && !rob_clear));
    if (sb.size() != 0) begin
      chk("val_id", 32'(update_val_id_out), 32'(sb[0].id));
      chk("val_dep", 32'(update_val_dep_out), 32'(sb[0].dep));
      chk("val_val", update_val_out, sb[0].val);
    end
    chk("dep_strobe", 32'(is_update_dep_out), 32'(rename_valid && !rob_clear));
    chk("dep_id", 32'(update_dep_id_out), 32'(rename_id));
    chk("dep_tag", 32'(update_dep_out), 32'(rename_dep));
    chk("qry_hit", 32'(qry_hit), 32'(eh));
    chk("qry_val", qry_val, ev);
  endtask

  task automatic cycle();
    #1 check();
    @(posedge clk_in); #1;
  endtask

  task automatic commit(input logic [4:0] id, input logic [TW-1:0] dep, input logic [31:0] val);
    commit_valid = 1; commit_id = id; commit_dep = dep; commit_val = val;
  endtask

  task automatic idle_until_empty();
    for (int n = 0; n < 20 && sb.size() != 0; n++) cycle();
    chk("drain_timeout", 32'(sb.size()), 0);
  endtask

  typedef struct {
    logic cv; logic [4:0] cid; logic [31:0] cval;
    logic rv; logic [4:0] rid; logic clr; logic rdy; logic [4:0] qid;
    logic exp_dep_strobe;
  } vec_t;
  vec_t vt[12];

  logic exp_hit;
  logic [31:0] exp_val;

  initial begin
    vt[0]  = '{1, 5'd3,  32'h00000aa1, 0, 5'd0,  0, 1, 5'd3,  0};
    vt[1]  = '{1, 5'd4,  32'h00000aa2, 1, 5'd4,  0, 1, 5'd3,  1};
    vt[2]  = '{1, 5'd3,  32'h00000aa3, 1, 5'd6,  1, 1, 5'd3,  0};
    vt[3]  = '{1, 5'd8,  32'h00000aa4, 0, 5'd0,  1, 1, 5'd4,  0};
    vt[4]  = '{1, 5'd9,  32'h00000aa5, 1, 5'd1,  1, 1, 5'd8,  0};
    vt[5]  = '{1, 5'd10, 32'h00000aa6, 0, 5'd0,  1, 1, 5'd3,  0};
    vt[6]  = '{1, 5'd11, 32'h00000aa7, 1, 5'd2,  0, 0, 5'd9,  1};
    vt[7]  = '{1, 5'd12, 32'h00000aa8, 0, 5'd0,  0, 0, 5'd0,  0};
    vt[8]  = '{1, 5'd0,  32'h00000aa9, 1, 5'd31, 0, 1, 5'd0,  1};
    vt[9]  = '{1, 5'd13, 32'h00000aaa, 0, 5'd0,  0, 1, 5'd13, 0};
    vt[10] = '{0, 5'd0,  32'h0,        1, 5'd5,  0, 1, 5'd13, 1};
    vt[11] = '{1, 5'd14, 32'h00000aab, 0, 5'd0,  0, 1, 5'd14, 0};

    // Reset state
    #3;
    chk("rst_ready", 32'(commit_ready), 1);
    chk("rst_val_strobe", 32'(is_update_val_out), 0);
    chk("rst_qry_hit", 32'(qry_hit), 0);
    chk("rst_qry_val", qry_val, 0);
    rename_valid = 1; #1;
    chk("rst_dep_strobe", 32'(is_update_dep_out), 1);
    rename_valid = 0;
    @(negedge clk_in) rst_in = 0;
    @(posedge clk_in); #1;

    // Single commit: one cycle to appear, gone the cycle after
    commit(5'd5, TW'(3), 32'hDEADBEEF);
    cycle();
    commit_valid = 0;
    #1;
    chk("single_strobe", 32'(is_update_val_out), 1);
    chk("single_id", 32'(update_val_id_out), 5);
    chk("single_dep", 32'(update_val_dep_out), 3);
    chk("single_val", update_val_out, 32'hDEADBEEF);
    cycle();
    chk("single_empty", 32'(is_update_val_out), 0);

    // Fill and full under a held rob_clear, then in-order drain
    rob_clear = 1;
    for (int k = 0; k < 5; k++) begin
      commit(5'(k + 1), TW'(k), 32'h100 + k);
      #1 chk("fill_ready", 32'(commit_ready), 32'(k < 4));
      cycle();
    end
    commit_valid = 0; rob_clear = 0;
    for (int k = 0; k < 4; k++) begin
      #1 chk("drain_strobe", 32'(is_update_val_out), 1);
      chk("drain_order", update_val_out, 32'h100 + k);
      cycle();
    end
    chk("drain_done", 32'(is_update_val_out), 0);

    // Flush: rename suppressed, queued entries survive
    rob_clear = 1;
    commit(5'd20, TW'(1), 32'hA0); cycle();
    commit(5'd21, TW'(2), 32'hA1); cycle();
    commit_valid = 0;
    rename_valid = 1; rename_id = 5'd7; rename_dep = TW'(2);
    #1 chk("flush_dep_strobe", 32'(is_update_dep_out), 0);
    chk("flush_val_strobe", 32'(is_update_val_out), 0);
    cycle();
    rob_clear = 0; rename_valid = 0;
    #1 chk("flush_resume", 32'(is_update_val_out), 1);
    chk("flush_first", update_val_out, 32'hA0);
    idle_until_empty();

    // x0 write: handshake completes, nothing queued
    commit(5'd0, TW'(0), 32'h1234);
    #1 chk("x0_ready", 32'(commit_ready), 1);
    cycle();
    commit_valid = 0;
    #1 chk("x0_no_strobe", 32'(is_update_val_out), 0);
    cycle();

    // Bypass: youngest match wins; gone after draining
    rob_clear = 1; qry_id = 5'd9;
    commit(5'd9, TW'(1), 32'h11); cycle();
    commit(5'd9, TW'(2), 32'h22); cycle();
    commit_valid = 0;
`ifdef RF_UPDATE_BYPASS_EN
    exp_hit = 1; exp_val = 32'h22;
`else
    exp_hit = 0; exp_val = 32'h0;
`endif
    #1 chk("byp_hit", 32'(qry_hit), 32'(exp_hit));
    chk("byp_val", qry_val, exp_val);
    rob_clear = 0;
    idle_until_empty();
    chk("byp_hit_gone", 32'(qry_hit), 0);
    qry_id = 0;

    // Reset mid-stream
    rob_clear = 1;
    for (int k = 0; k < 3; k++) begin commit(5'(k + 2), TW'(k), 32'h300 + k); cycle(); end
    commit_valid = 0; rob_clear = 0;
    #1 chk("pre_rst_strobe", 32'(is_update_val_out), 1);
    rst_in = 1;
    #1 chk("mid_rst_strobe", 32'(is_update_val_out), 0);
    chk("mid_rst_ready", 32'(commit_ready), 1);
    #1 rst_in = 0;
    @(posedge clk_in); #1;
    commit(5'd17, TW'(5), 32'h777); cycle();
    commit_valid = 0;
    #1 chk("post_rst_val", update_val_out, 32'h777);
    idle_until_empty();

    // Table-driven mixed traffic, model-checked every cycle
    foreach (vt[i]) begin
      commit_valid = vt[i].cv; commit_id = vt[i].cid; commit_dep = TW'(i);
      commit_val = vt[i].cval; rename_valid = vt[i].rv; rename_id = vt[i].rid;
      rename_dep = TW'(i + 1); rob_clear = vt[i].clr; rdy_in = vt[i].rdy; qry_id = vt[i].qid;
      #1 chk("tbl_dep_strobe", 32'(is_update_dep_out), 32'(vt[i].exp_dep_strobe));
      cycle();
    end
    commit_valid = 0; rename_valid = 0; rob_clear = 0; rdy_in = 1;
    idle_until_empty();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
